fifo_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_counter.sv | 48 ++++
 rtl/fifo_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-fed serial transmitter:
//   uart_state_e     - transmitter FSM states
//   LINE_IDLE        - level the serial line rests at between frames
//   DEFAULT_CLK_DIV  - default clock cycles per serial bit
//   cnt_width()      - counter width helper that never returns zero
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic LINE_IDLE       = 1'b1;
    localparam int   DEFAULT_CLK_DIV = 16;

    // Width needed to hold 0..n-1; at least one bit so that degenerate
    // parameter values still give a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Divides clk_i by CLK_DIV. Counts 0..CLK_DIV-1 and wraps; restart_i forces
// the count back to 0 on the next edge.
// Ports:
//   clk_i      - system clock
//   rst_i      - asynchronous, active-low reset
//   restart_i  - synchronous clear (takes priority over counting)
//   count_o    - current count value
//   tick_o     - high for the single cycle in which count == CLK_DIV-1
// -----------------------------------------------------------------------------
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    localparam int CNT_W  = cnt_width(CLK_DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (restart_i || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tick_o  = (count_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Serial transmitter that drains a byte FIFO from its read side. Whenever the
// FIFO is non-empty and enable_i is high it pops one word and sends it as
// start bit, WIDTH data bits LSB first, then STOP_BITS stop bits.
// Ports:
//   clk_i      - system clock
//   rst_i      - asynchronous, active-low reset
//   data_i     - FIFO head word, valid while size_i != 0
//   size_i     - FIFO fill level
//   getData_o  - one-cycle pop strobe back to the FIFO (registered)
//   enable_i   - permits starting new frames
//   tx_o       - serial line, idles high (registered)
//   busy_o     - high while a word is being popped or transmitted (registered)
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int WIDTH      = 8,
    parameter int SIZE_WIDTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic [SIZE_WIDTH-1:0] size_i,
    output logic                  getData_o,
    input  logic                  enable_i,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int CNT_W = cnt_width(CLK_DIV);
    localparam int BIT_W = cnt_width((WIDTH > STOP_BITS) ? WIDTH : STOP_BITS);

    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP_BIT = BIT_W'(STOP_BITS - 1);
    // The pop strobe is registered, so the decision to pop at the end of a
    // frame is taken one cycle before the final stop cycle.
    localparam logic [CNT_W-1:0] PRE_TICK      = CNT_W'(CLK_DIV - 2);

    uart_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic             get_q,   get_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;

    logic             baud_restart;
    logic             baud_tick;
    logic [CNT_W-1:0] baud_count;
    logic             can_pop;
    logic             last_stop;

    uart_baud_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (baud_restart),
        .count_o   (baud_count),
        .tick_o    (baud_tick)
    );

    assign can_pop   = enable_i && (size_i != '0);
    assign last_stop = (bit_q == LAST_STOP_BIT);

    // Every bit period starts at count 0: the counter is held while idle and
    // cleared on each state change.
    assign baud_restart = (state_q == IDLE) || (state_d != state_q);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        get_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (get_q) begin
                    // Pop cycle: FIFO advances on this edge, capture its head.
                    shift_d = data_i;
                    bit_d   = '0;
                    state_d = START;
                end else if (can_pop) begin
                    get_d = 1'b1;
                end
            end

            START: begin
                if (baud_tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (bit_q == LAST_DATA_BIT) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end

            STOP: begin
                // Schedule the pop so it lands on the final stop cycle,
                // giving back-to-back frames with no idle gap.
                if (last_stop && (baud_count == PRE_TICK) && can_pop) begin
                    get_d = 1'b1;
                end
                if (baud_tick) begin
                    if (last_stop) begin
                        bit_d = '0;
                        if (get_q) begin
                            shift_d = data_i;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the state being entered, so tx_o is registered
        // yet aligned with the state it belongs to.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = LINE_IDLE;
        endcase

        busy_d = (state_d != IDLE) || get_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            get_q   <= 1'b0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            get_q   <= get_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign getData_o = get_q;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Two transmitters share clock and reset: channel 0 with one stop bit and
// channel 1 with two. Each has a small FIFO model; expected bytes go into a
// per-channel queue and a receiver process decodes the line and compares.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] en_r;
    logic [7:0] data_r [2];
    logic [3:0] size_r [2];
    wire  [1:0] tx_w;
    wire  [1:0] get_w;
    wire  [1:0] busy_w;

    logic [7:0] fifo_q [2][$];
    logic [7:0] exp_q  [2][$];
    int         pop_cnt  [2];
    int         last_pop [2];
    int         cyc;
    int         n_tests;
    int         n_fail;

    fifo_uart_tx #(.CLK_DIV(DIV), .WIDTH(8), .SIZE_WIDTH(4), .STOP_BITS(1)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .data_i(data_r[0]), .size_i(size_r[0]),
        .getData_o(get_w[0]), .enable_i(en_r[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0])
    );

    fifo_uart_tx #(.CLK_DIV(DIV), .WIDTH(8), .SIZE_WIDTH(4), .STOP_BITS(2)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .data_i(data_r[1]), .size_i(size_r[1]),
        .getData_o(get_w[1]), .enable_i(en_r[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end else begin
            $display("[TB] ok   %s = %0d at cycle %0d", name, act, cyc);
        end
    endtask

    task automatic refresh(input int ch);
        size_r[ch] = 4'(fifo_q[ch].size());
        data_r[ch] = (fifo_q[ch].size() > 0) ? fifo_q[ch][0] : 8'h00;
    endtask

    task automatic push(input int ch, input logic [7:0] b, input bit expect_tx);
        fifo_q[ch].push_back(b);
        if (expect_tx) exp_q[ch].push_back(b);
        refresh(ch);
    endtask

    // FIFO read side: checks every pop is legal, then advances the model just
    // after the edge on which the DUT captured the head word.
    task automatic fifo_loop(input int ch);
        bit prev;
        bit pend;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            pend = rst_n && get_w[ch];
            if (pend) begin
                n_tests++;
                if (size_r[ch] == 4'd0 || prev) begin
                    n_fail++;
                    $display("FAIL pop_legal ch%0d: size=%0d prev_pop=%0d, required size!=0 and no back-to-back strobe",
                             ch, size_r[ch], prev);
                end
                pop_cnt[ch]++;
                last_pop[ch] = cyc;
                $display("[TB] pop  ch%0d word 0x%02h at cycle %0d", ch, data_r[ch], cyc);
            end
            prev = pend;
            if (pend) begin
                @(posedge clk);
                #1;
                if (fifo_q[ch].size() > 0) void'(fifo_q[ch].pop_front());
                refresh(ch);
            end
        end
    endtask

    // Line receiver: checks every cycle of a frame against the expected byte.
    task automatic rx_loop(input int ch, input int sb);
        int         n;
        int         bad;
        int         start;
        int         sp;
        int         b;
        bit         ok;
        logic       expbit;
        logic [7:0] got;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (rst_n && tx_w[ch] == 1'b0) begin
                start = cyc;
                sp    = last_pop[ch];
                n     = (1 + 8 + sb) * DIV;
                bad   = 0;
                got   = 8'h00;
                ok    = 1'b1;
                want  = (exp_q[ch].size() > 0) ? exp_q[ch][0] : 8'h00;
                for (int k = 0; k < n; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_n) begin
                        ok = 1'b0;
                        break;
                    end
                    b = k / DIV;
                    if (b == 0)      expbit = 1'b0;
                    else if (b <= 8) expbit = want[b-1];
                    else             expbit = 1'b1;
                    if (tx_w[ch] !== expbit) bad++;
                    if (b >= 1 && b <= 8 && (k % DIV) == DIV / 2) got[b-1] = tx_w[ch];
                end
                if (ok) begin
                    check($sformatf("start_latency ch%0d", ch), start - sp, 1);
                    if (exp_q[ch].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame ch%0d: got unexpected frame 0x%02h, required no frame", ch, got);
                    end else begin
                        void'(exp_q[ch].pop_front());
                        check($sformatf("frame_bad_cycles ch%0d", ch), bad, 0);
                        check($sformatf("frame_byte ch%0d", ch), int'(got), int'(want));
                    end
                end else begin
                    $display("[TB] rx   ch%0d frame abandoned by reset at cycle %0d", ch, cyc);
                end
            end
        end
    endtask

    task automatic wait_pop(input int ch, input int maxc, output int t);
        t = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (get_w[ch]) begin
                t = cyc;
                break;
            end
        end
        n_tests++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL pop_wait ch%0d: got no getData within %0d cycles, required one", ch, maxc);
            t = cyc;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial fifo_loop(0);
    initial fifo_loop(1);
    initial rx_loop(0, 1);
    initial rx_loop(1, 2);

    initial begin
        int t0;
        int t1;
        int t2;
        int pc;
        int viol;

        n_tests     = 0;
        n_fail      = 0;
        pop_cnt[0]  = 0;
        pop_cnt[1]  = 0;
        last_pop[0] = 0;
        last_pop[1] = 0;
        rst_n       = 1'b0;
        en_r        = 2'b00;
        refresh(0);
        refresh(1);

        // 1. Reset state held across clock edges.
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs ch0", {tx_w[0], get_w[0], busy_w[0]}, 3'b100);
            check("reset_outputs ch1", {tx_w[1], get_w[1], busy_w[1]}, 3'b100);
        end
        rst_n = 1'b1;

        // 2. Single byte 0xA5.
        repeat (2) @(negedge clk);
        en_r[0] = 1'b1;
        push(0, 8'hA5, 1'b1);
        wait_pop(0, 10, t0);
        @(negedge clk);
        check("single_pop_width", get_w[0], 0);
        wait_until(t0 + 40);
        check("busy_last_stop", busy_w[0], 1);
        wait_until(t0 + 41);
        check("busy_after_frame", busy_w[0], 0);
        check("tx_idle_after_frame", tx_w[0], 1);

        // 3. Back-to-back 0x01, 0x80.
        repeat (3) @(negedge clk);
        push(0, 8'h01, 1'b1);
        push(0, 8'h80, 1'b1);
        wait_pop(0, 10, t1);
        wait_pop(0, 60, t2);
        check("b2b_pop_spacing", t2 - t1, 40);
        wait_until(t2 + 45);
        check("b2b_busy_end", busy_w[0], 0);

        // 4. Enable gating.
        en_r[0] = 1'b0;
        pc = pop_cnt[0];
        push(0, 8'h3C, 1'b1);
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (get_w[0] !== 1'b0 || tx_w[0] !== 1'b1) viol++;
        end
        check("gated_idle_violations", viol, 0);
        check("gated_no_pop", pop_cnt[0], pc);
        en_r[0] = 1'b1;
        wait_pop(0, 10, t0);
        wait_until(t0 + 10);
        en_r[0] = 1'b0;
        wait_until(t0 + 60);
        check("gated_single_pop", pop_cnt[0], pc + 1);
        check("gated_fifo_left", int'(size_r[0]), 2);
        fifo_q[0].delete();
        refresh(0);

        // 5. Reset during DATA bit 3, then a fresh frame.
        en_r[0] = 1'b1;
        push(0, 8'h5A, 1'b0);
        wait_pop(0, 10, t0);
        wait_until(t0 + 18);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {tx_w[0], get_w[0], busy_w[0]}, 3'b100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_word_lost", int'(size_r[0]), 0);
        push(0, 8'hC3, 1'b1);
        wait_pop(0, 10, t0);
        wait_until(t0 + 45);
        check("after_reset_busy_end", busy_w[0], 0);

        // 6. Two stop bits: 0xFF then 0x00 back to back.
        en_r[1] = 1'b1;
        push(1, 8'hFF, 1'b1);
        push(1, 8'h00, 1'b1);
        wait_pop(1, 10, t1);
        wait_pop(1, 60, t2);
        check("two_stop_pop_spacing", t2 - t1, 44);
        wait_until(t2 + 50);
        check("two_stop_busy_end", busy_w[1], 0);

        check("all_frames_seen ch0", exp_q[0].size(), 0);
        check("all_frames_seen ch1", exp_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
